mem_stage: RTL and testbench

Fourth stage of the five-stage in-order LoongArch pipeline, between the execute stage and the write-back stage. Holds one instruction per cycle. Loads wait here for the data SRAM response, with a one-entry buffer for early-arriving read data. Load data is aligned and sign/zero-extended here; non-loads pass the ALU result through. Forwards its destination, write enable and result to decode for bypass and load-use stalls.

---
 rtl/mem_stage_pkg.sv | 35 +++
 rtl/mem_stage_checker.sv | 22 ++
 rtl/mem_stage_load_align.sv | 44 ++++
 rtl/mem_stage.sv | 96 +++++++++
 tb/tb_mem_stage.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types, bus widths and load-op encodings for the memory stage.
// Field layouts mirror the inter-stage bus packing, MSB first.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 76;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_TO_DS_BUS_WD = 39;

    typedef enum logic [2:0] {
        LOAD_OP_W  = 3'd0,
        LOAD_OP_B  = 3'd1,
        LOAD_OP_H  = 3'd2,
        LOAD_OP_BU = 3'd3,
        LOAD_OP_HU = 3'd4
    } load_op_e;

    typedef struct packed {
        logic        res_from_mem;
        logic [2:0]  load_op;
        logic [1:0]  addr_low;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_bus_t;

    function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic sign);
        return {{24{sign & b[7]}}, b};
    endfunction

    function automatic logic [31:0] extend_half(input logic [15:0] h, input logic sign);
        return {{16{sign & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_stage_checker.sv
// Protocol properties for the memory stage handshake and response buffer.
// A stray data_ok (empty stage or non-load) is legal-but-ignored, so it is only covered.
module mem_stage_checker (
    input logic clk,
    input logic reset,
    input logic ms_valid,
    input logic res_from_mem,
    input logic buf_valid,
    input logic data_ok,
    input logic ms_to_ws_valid
);

    buf_holds_live_load: assert property (@(posedge clk) disable iff (reset)
        buf_valid |-> (ms_valid && res_from_mem));

    offer_needs_valid: assert property (@(posedge clk) disable iff (reset)
        ms_to_ws_valid |-> ms_valid);

    stray_data_ok: cover property (@(posedge clk) disable iff (reset)
        data_ok && !(ms_valid && res_from_mem));

endmodule

// File: rtl/mem_stage_load_align.sv
// Lane selection and sign/zero extension of SRAM read data for loads.
// Unused load_op codes fall back to a full-word load.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  load_op,
    input  logic [1:0]  addr_low,
    output logic [31:0] ext_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword lanes
    always_comb begin
        byte_s = rdata[7:0];
        case (addr_low)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (addr_low[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extend the selected lane according to the load flavour
    always_comb begin
        ext_data = rdata;
        case (load_op)
            LOAD_OP_B:  ext_data = extend_byte(byte_s, 1'b1);
            LOAD_OP_BU: ext_data = extend_byte(byte_s, 1'b0);
            LOAD_OP_H:  ext_data = extend_half(half_s, 1'b1);
            LOAD_OP_HU: ext_data = extend_half(half_s, 1'b0);
            default:    ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: holds one instruction, waits for load data, buffers early
// responses while write-back stalls, and feeds the decode bypass network.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata
);

    logic          ms_valid_r;
    es_to_ms_bus_t bus_r;
    logic          buf_valid_r;
    logic [31:0]   rdata_buf_r;

    logic          ms_ready_go_s;
    logic          ms_leave_s;
    logic          buf_set_s;
    logic          load_pending_s;
    logic [31:0]   rdata_sel_s;
    logic [31:0]   ext_data_s;
    logic [31:0]   final_result_s;

    // data_ok reaches ms_to_ws_valid combinationally so a prompt load costs no extra cycle
    assign ms_ready_go_s  = !bus_r.res_from_mem || data_sram_data_ok || buf_valid_r;
    assign ms_allowin     = !ms_valid_r || (ms_ready_go_s && ws_allowin);
    assign ms_to_ws_valid = ms_valid_r && ms_ready_go_s;
    assign ms_leave_s     = ms_to_ws_valid && ws_allowin;
    assign buf_set_s      = ms_valid_r && bus_r.res_from_mem && data_sram_data_ok
                            && !buf_valid_r && !ws_allowin;
    assign load_pending_s = ms_valid_r && bus_r.res_from_mem && !ms_ready_go_s;
    assign rdata_sel_s    = buf_valid_r ? rdata_buf_r : data_sram_rdata;

    load_align u_load_align (
        .rdata    (rdata_sel_s),
        .load_op  (bus_r.load_op),
        .addr_low (bus_r.addr_low),
        .ext_data (ext_data_s)
    );

    // Choose between extended load data and the ALU result
    always_comb begin
        final_result_s = bus_r.alu_result;
        if (bus_r.res_from_mem) begin
            final_result_s = ext_data_s;
        end else begin
            final_result_s = bus_r.alu_result;
        end
    end

    assign ms_to_ws_bus = {bus_r.gr_we, bus_r.dest, final_result_s, bus_r.pc};
    assign ms_to_ds_bus = {ms_valid_r && bus_r.gr_we, bus_r.dest, final_result_s, load_pending_s};

    // Stage occupancy, captured instruction and early-response buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_r  <= 1'b0;
            bus_r       <= '0;
            buf_valid_r <= 1'b0;
            rdata_buf_r <= 32'h0000_0000;
        end else begin
            if (ms_allowin) begin
                ms_valid_r <= es_to_ms_valid;
            end
            if (es_to_ms_valid && ms_allowin) begin
                bus_r <= es_to_ms_bus_t'(es_to_ms_bus);
            end
            // leave and set are exclusive: set requires write-back to be stalled
            if (ms_leave_s) begin
                buf_valid_r <= 1'b0;
            end else if (buf_set_s) begin
                buf_valid_r <= 1'b1;
                rdata_buf_r <= data_sram_rdata;
            end
        end
    end

    mem_stage_checker u_checker (
        .clk            (clk),
        .reset          (reset),
        .ms_valid       (ms_valid_r),
        .res_from_mem   (bus_r.res_from_mem),
        .buf_valid      (buf_valid_r),
        .data_ok        (data_sram_data_ok),
        .ms_to_ws_valid (ms_to_ws_valid)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected write-back buses into a
// queue, a monitor pops and compares each time write-back accepts an instruction.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [75:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [38:0] ms_to_ds_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [69:0] exp_q[$];
    logic [69:0] mon_e;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ds_bus      (ms_to_ds_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [75:0] mk_es(input logic res, input logic [2:0] op, input logic [1:0] al,
                                          input logic we, input logic [4:0] d,
                                          input logic [31:0] alu, input logic [31:0] pc);
        return {res, op, al, we, d, alu, pc};
    endfunction

    function automatic logic [69:0] mk_ws(input logic we, input logic [4:0] d,
                                          input logic [31:0] r, input logic [31:0] pc);
        return {we, d, r, pc};
    endfunction

    task automatic drive(input logic v, input logic [75:0] bus, input logic ok,
                         input logic [31:0] rd, input logic wsa);
        es_to_ms_valid    = v;
        es_to_ms_bus      = bus;
        data_sram_data_ok = ok;
        data_sram_rdata   = rd;
        ws_allowin        = wsa;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one expected entry per accepted instruction
    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected no output", ms_to_ws_bus);
            end else begin
                mon_e = exp_q.pop_front();
                check("ws_bus", 76'(ms_to_ws_bus), 76'(mon_e));
                check("fwd_result", 76'(ms_to_ds_bus[32:1]), 76'(mon_e[63:32]));
                check("fwd_we", 76'(ms_to_ds_bus[38]), 76'(mon_e[69]));
            end
        end
    end

    logic [2:0]  ld_op [7] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd1, 3'd0, 3'd6};
    logic [1:0]  ld_al [7] = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd2, 2'd1};
    logic [31:0] ld_ex [7] = '{32'h0000_007F, 32'h0000_0080, 32'hFFFF_8081, 32'h0000_7F82,
                               32'hFFFF_FF82, 32'h8081_7F82, 32'h8081_7F82};

    initial begin
        logic [31:0] pc;
        reset = 1'b1;
        drive(1'b0, 76'd0, 1'b0, 32'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_allowin", 76'(ms_allowin), 76'd1);
        check("rst_ws_valid", 76'(ms_to_ws_valid), 76'd0);
        check("rst_ws_bus", 76'(ms_to_ws_bus), 76'd0);
        check("rst_ds_bus", 76'(ms_to_ds_bus), 76'd0);
        step();

        // non-load pass-through
        pc = 32'h1C00_0000;
        drive(1'b1, mk_es(1'b0, 3'd0, 2'd0, 1'b1, 5'd5, 32'h1234_5678, pc), 1'b0, 32'd0, 1'b1);
        exp_q.push_back(mk_ws(1'b1, 5'd5, 32'h1234_5678, pc));
        step();
        drive(1'b0, 76'd0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        check("alu_ws_valid", 76'(ms_to_ws_valid), 76'd1);
        check("alu_fwd_bus", 76'(ms_to_ds_bus), 76'({1'b1, 5'd5, 32'h1234_5678, 1'b0}));
        step();

        // back-to-back loads, data_ok in each entry cycle
        for (int i = 0; i <= 7; i++) begin
            if (i < 7) begin
                pc = 32'h1C00_0100 + 32'(i * 4);
                drive(1'b1, mk_es(1'b1, ld_op[i], ld_al[i], 1'b1, 5'(10 + i), 32'hA5A5_0000, pc),
                      (i > 0), 32'h8081_7F82, 1'b1);
                exp_q.push_back(mk_ws(1'b1, 5'(10 + i), ld_ex[i], pc));
            end else begin
                drive(1'b0, 76'd0, 1'b1, 32'h8081_7F82, 1'b1);
            end
            @(negedge clk);
            check("b2b_allowin", 76'(ms_allowin), 76'd1);
            step();
        end
        drive(1'b0, 76'd0, 1'b0, 32'd0, 1'b1);
        step();

        // late response
        pc = 32'h1C00_0200;
        drive(1'b1, mk_es(1'b1, 3'd0, 2'd0, 1'b1, 5'd7, 32'hA5A5_0000, pc), 1'b0, 32'd0, 1'b1);
        exp_q.push_back(mk_ws(1'b1, 5'd7, 32'hCAFE_F00D, pc));
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 76'd0, 1'b0, 32'd0, 1'b1);
            @(negedge clk);
            check("late_pending", 76'(ms_to_ds_bus[0]), 76'd1);
            check("late_allowin", 76'(ms_allowin), 76'd0);
            check("late_ws_valid", 76'(ms_to_ws_valid), 76'd0);
            step();
        end
        drive(1'b0, 76'd0, 1'b1, 32'hCAFE_F00D, 1'b1);
        @(negedge clk);
        check("late_ok_valid", 76'(ms_to_ws_valid), 76'd1);
        step();

        // write-back stall with buffered response
        pc = 32'h1C00_0300;
        drive(1'b1, mk_es(1'b1, 3'd0, 2'd0, 1'b1, 5'd9, 32'hA5A5_0000, pc), 1'b0, 32'd0, 1'b1);
        exp_q.push_back(mk_ws(1'b1, 5'd9, 32'hDEAD_BEEF, pc));
        step();
        drive(1'b0, 76'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        check("stall0_result", 76'(ms_to_ws_bus[63:32]), 76'h0000_DEAD_BEEF);
        check("stall0_allowin", 76'(ms_allowin), 76'd0);
        step();
        drive(1'b0, 76'd0, 1'b0, 32'h1357_9BDF, 1'b0);
        @(negedge clk);
        check("stall1_result", 76'(ms_to_ws_bus[63:32]), 76'h0000_DEAD_BEEF);
        check("stall1_valid", 76'(ms_to_ws_valid), 76'd1);
        check("stall1_pending", 76'(ms_to_ds_bus[0]), 76'd0);
        step();
        pc = 32'h1C00_0304;
        drive(1'b1, mk_es(1'b1, 3'd0, 2'd0, 1'b1, 5'd11, 32'hA5A5_0000, pc), 1'b0, 32'h1357_9BDF, 1'b1);
        exp_q.push_back(mk_ws(1'b1, 5'd11, 32'h0BAD_F00D, pc));
        step();
        drive(1'b0, 76'd0, 1'b0, 32'h1357_9BDF, 1'b1);
        @(negedge clk);
        check("fresh_pending", 76'(ms_to_ds_bus[0]), 76'd1);
        check("fresh_ws_valid", 76'(ms_to_ws_valid), 76'd0);
        step();
        drive(1'b0, 76'd0, 1'b1, 32'h0BAD_F00D, 1'b1);
        step();

        // reset while a load waits, then a stray data_ok
        pc = 32'h1C00_0400;
        drive(1'b1, mk_es(1'b1, 3'd0, 2'd0, 1'b1, 5'd3, 32'hA5A5_0000, pc), 1'b0, 32'd0, 1'b1);
        step();
        drive(1'b0, 76'd0, 1'b0, 32'd0, 1'b1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 76'd0, 1'b1, 32'h55AA_55AA, 1'b1);
        @(negedge clk);
        check("mid_rst_ws_valid", 76'(ms_to_ws_valid), 76'd0);
        check("mid_rst_allowin", 76'(ms_allowin), 76'd1);
        check("mid_rst_ws_bus", 76'(ms_to_ws_bus), 76'd0);
        check("mid_rst_ds_bus", 76'(ms_to_ds_bus), 76'd0);
        step();
        drive(1'b0, 76'd0, 1'b0, 32'd0, 1'b1);
        repeat (3) step();

        check("queue_drained", 76'(exp_q.size()), 76'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
